bcd_cnt_n: RTL
==============

BCD_CNT_N -- requirements
Module: bcd_cnt_n

Interface
REQ-001 Parameter DIGITS, default 3, number of BCD digits (1..6).
REQ-002 Parameter MIN_BCD, default 0, BCD wrap-to value (4*DIGITS bits).
REQ-003 Parameter MAX_BCD, default 'h100, BCD terminal value (4*DIGITS bits); MIN_BCD < MAX_BCD.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 ENABLE  in  1  run-mode count enable (1 Hz tick domain).
REQ-007 CARRY_in  in  1  carry from lower-order counter.
REQ-008 SET_CURRENT_STATE  in  2  bit0 = run mode, bit1 = set mode.
REQ-009 INC_MODE  in  1  set-mode increment request, one step per cycle high.
REQ-010 DEC_MODE  in  1  set-mode decrement request; present only with BCD_CNT_DOWN_EN.
REQ-011 LOAD  in  1  synchronous load strobe.
REQ-012 LOAD_VAL  in  4*DIGITS  BCD value to load.
REQ-013 CNT  out  4*DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-014 CARRY_out  out  1  combinational carry to higher-order counter.
REQ-015 WRAPPED  out  1  registered one-cycle pulse, cycle after any wrap.

Function
REQ-016 run_step = ENABLE & CARRY_in & SET_CURRENT_STATE[0] & ~SET_CURRENT_STATE[1]; SET_CURRENT_STATE = 2'b11 is set mode.
REQ-017 set_inc = SET_CURRENT_STATE[1] & INC_MODE; set_dec = SET_CURRENT_STATE[1] & DEC_MODE & ~INC_MODE.
REQ-018 Priority per cycle: LOAD > set_inc/set_dec > run_step; lower-priority events in that cycle are dropped.
REQ-019 Increment: digit i increments when all digits below equal 9; digit at 9 becomes 0 (ripple BCD, no binary overflow).
REQ-020 Increment with CNT == MAX_BCD: CNT <= MIN_BCD, WRAPPED = 1 next cycle.
REQ-021 Decrement with CNT == MIN_BCD: CNT <= MAX_BCD, WRAPPED = 1 next cycle; digit at 0 borrows to 9.
REQ-022 CARRY_out = run_step & (CNT == MAX_BCD), same cycle, zero latency; set-mode wraps never assert CARRY_out.
REQ-023 LOAD: valid LOAD_VAL (all digits <= 9, MIN_BCD <= value <= MAX_BCD) written to CNT next edge; otherwise CNT <= MIN_BCD.
REQ-024 CNT changes only on REQ-018 events; all other cycles hold.
REQ-025 WRAPPED is 0 in every cycle not following a wrap.

Reset
REQ-026 RESET high: CNT = MIN_BCD, WRAPPED = 0 immediately, independent of CLK.
REQ-027 CARRY_out = 0 while RESET high.
REQ-028 RESET deassertion mid-sequence: first counting edge starts from MIN_BCD; no pending event retained.

Configuration
REQ-029 Macro BCD_CNT_DOWN_EN defined: DEC_MODE port present and REQ-017/REQ-021 decrement active.
REQ-030 Macro BCD_CNT_DOWN_EN undefined: DEC_MODE port absent, set mode increments only; all other behaviour identical.

Verification (DIGITS=3, MIN_BCD=0, MAX_BCD='h100)
REQ-031 RESET pulse with CNT='h057 -> CNT='h000, WRAPPED=0 before next CLK edge.
REQ-032 Run mode, ENABLE=CARRY_in=1 from 'h098 -> 'h099, 'h100, then 'h000 with CARRY_out=1 during 'h100 cycle and WRAPPED=1 the following cycle.
REQ-033 SET_CURRENT_STATE=2'b10, INC_MODE=1 at 'h100 -> CNT='h000, CARRY_out stays 0, WRAPPED=1.
REQ-034 LOAD=1, LOAD_VAL='h0A5 -> CNT='h000; LOAD_VAL='h042 with INC_MODE=1 same cycle -> CNT='h042.
REQ-035 BCD_CNT_DOWN_EN defined, set mode, DEC_MODE=1 at 'h000 -> 'h100; at 'h010 -> 'h009.
REQ-036 SET_CURRENT_STATE=2'b11, ENABLE=CARRY_in=1, INC_MODE=0 -> CNT holds, CARRY_out=0.

Source files
------------

// File: rtl/bcd_cnt_n.sv
`default_nettype none
// ============================================================================
// bcd_cnt_n : cascadable N-digit BCD counter with run/set modes, load, wrap flag
// Optional feature macro: BCD_CNT_DOWN_EN (adds DEC_MODE and set-mode decrement)
// Revision  : 1.0
// ============================================================================
module bcd_cnt_n #(
  parameter int                    DIGITS  = 3,
  parameter logic [4*DIGITS-1:0]   MIN_BCD = '0,
  parameter logic [4*DIGITS-1:0]   MAX_BCD = (4*DIGITS)'('h100)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  CARRY_in,
  input  logic [1:0]            SET_CURRENT_STATE,
  input  logic                  INC_MODE,
`ifdef BCD_CNT_DOWN_EN
  input  logic                  DEC_MODE,
`endif
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   CNT,
  output logic                  CARRY_out,
  output logic                  WRAPPED
);

  localparam int W = 4 * DIGITS;

  logic          run_step;
  logic          set_inc;
  logic          set_dec;
  logic          load_ok;
  logic          at_max;
  logic          at_min;
  logic [W-1:0]  cnt_inc;
  logic [W-1:0]  cnt_dec;
  logic [DIGITS-1:0] inc_c;
  logic [DIGITS-1:0] dec_b;
  logic [DIGITS-1:0] dig_ok;

  assign run_step = ENABLE & CARRY_in & SET_CURRENT_STATE[0] & ~SET_CURRENT_STATE[1];
  assign set_inc  = SET_CURRENT_STATE[1] & INC_MODE;
`ifdef BCD_CNT_DOWN_EN
  assign set_dec  = SET_CURRENT_STATE[1] & DEC_MODE & ~INC_MODE;
`else
  assign set_dec  = 1'b0;
`endif

  assign at_max = (CNT == MAX_BCD);
  assign at_min = (CNT == MIN_BCD);

  // Ripple BCD carry/borrow chains: digit i moves only when every lower digit rolls over.
  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    assign d = CNT[4*i +: 4];
    assign cnt_inc[4*i +: 4] = inc_c[i] ? ((d >= 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign cnt_dec[4*i +: 4] = dec_b[i] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    assign dig_ok[i] = (LOAD_VAL[4*i +: 4] <= 4'd9);
    if (i < DIGITS - 1) begin : g_chain
      assign inc_c[i+1] = inc_c[i] & (d >= 4'd9);
      assign dec_b[i+1] = dec_b[i] & (d == 4'd0);
    end
  end

  // Valid BCD compares correctly as binary; the guard bit keeps the range check non-trivial.
  assign load_ok = (&dig_ok) &&
                   ({1'b1, LOAD_VAL} >= {1'b1, MIN_BCD}) &&
                   ({1'b1, LOAD_VAL} <= {1'b1, MAX_BCD});

  assign CARRY_out = run_step & at_max & ~RESET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CNT     <= MIN_BCD;
      WRAPPED <= 1'b0;
    end else begin
      WRAPPED <= 1'b0;
      if (LOAD) begin
        CNT <= load_ok ? LOAD_VAL : MIN_BCD;
      end else if (set_inc || run_step) begin
        if (at_max) begin
          CNT     <= MIN_BCD;
          WRAPPED <= 1'b1;
        end else begin
          CNT <= cnt_inc;
        end
      end else if (set_dec) begin
        if (at_min) begin
          CNT     <= MAX_BCD;
          WRAPPED <= 1'b1;
        end else begin
          CNT <= cnt_dec;
        end
      end
    end
  end

endmodule
`default_nettype wire
